// File: rtl/i2c_bus_monitor.sv
`default_nettype none
// ============================================================================
// Module   : i2c_bus_monitor
// Purpose  : Wired-AND I2C bus model with glitch filter, START/Sr/STOP and
//            byte/ACK decoder, event FIFO, overflow and SCL-low timeout flags.
// Revision : 1.0 - initial release
// ============================================================================
module i2c_bus_monitor #(
    parameter int PORTS      = 2,
    parameter int FILTER_LEN = 4,
    parameter int FIFO_DEPTH = 16,
    parameter int TIMEOUT    = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [PORTS-1:0] scl_o,
    input  logic [PORTS-1:0] sda_o,
    input  logic             scl_i,
    input  logic             sda_i,
    output logic             bus_scl,
    output logic             bus_sda,
    output logic [7:0]       m_axis_tdata,
    output logic [2:0]       m_axis_tuser,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready,
    output logic             bus_busy,
    output logic             overflow,
    input  logic             overflow_clr,
    output logic             timeout
);
    localparam int c_fcw = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int c_aw  = $clog2(FIFO_DEPTH);
    localparam int c_tw  = $clog2(TIMEOUT + 1);

    localparam logic [c_fcw-1:0] c_fmax  = c_fcw'(FILTER_LEN - 1);
    localparam logic [c_aw:0]    c_depth = (c_aw + 1)'(FIFO_DEPTH);
    localparam logic [c_tw-1:0]  c_tmax  = c_tw'(TIMEOUT);

    localparam logic [1:0] c_ev_byte   = 2'd0;
    localparam logic [1:0] c_ev_start  = 2'd1;
    localparam logic [1:0] c_ev_rstart = 2'd2;
    localparam logic [1:0] c_ev_stop   = 2'd3;

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_ACTIVE = 1'b1} state_t;

    // ---------------- bus resolution and filtering ----------------
    logic [1:0] w_raw;
    logic [1:0] w_filt;

    assign bus_scl = &scl_o & scl_i;
    assign bus_sda = &sda_o & sda_i;
    assign w_raw   = {bus_sda, bus_scl};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_filter
            logic             r_sync;
            logic             r_filt;
            logic [c_fcw-1:0] r_cnt;

            // Counter restarts whenever the sampled line agrees with the filtered value.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_sync <= 1'b1;
                    r_filt <= 1'b1;
                    r_cnt  <= '0;
                end else begin
                    r_sync <= w_raw[gi];
                    if (r_sync == r_filt) begin
                        r_cnt <= '0;
                    end else if (r_cnt == c_fmax) begin
                        r_filt <= r_sync;
                        r_cnt  <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            end

            assign w_filt[gi] = r_filt;
        end
    endgenerate

    logic w_scl, w_sda;
    logic r_scl_prev, r_sda_prev;
    logic w_scl_edge, w_sda_edge, w_scl_rise, w_start, w_stop;

    assign w_scl      = w_filt[0];
    assign w_sda      = w_filt[1];
    assign w_scl_edge = w_scl ^ r_scl_prev;
    assign w_sda_edge = w_sda ^ r_sda_prev;
    assign w_scl_rise = w_scl & ~r_scl_prev;
    // SDA transitions only count as conditions while SCL is high and steady.
    assign w_start    = w_sda_edge & ~w_sda & w_scl & ~w_scl_edge;
    assign w_stop     = w_sda_edge &  w_sda & w_scl & ~w_scl_edge;

    // ---------------- protocol decoder ----------------
    state_t     r_state, w_state_nxt;
    logic [3:0] r_bitcnt, w_bitcnt_nxt;
    logic [7:0] r_shift, w_shift_nxt;
    logic       w_ev_vld, w_ev_nack;
    logic [1:0] w_ev_type;

    always_comb begin
        w_state_nxt  = r_state;
        w_bitcnt_nxt = r_bitcnt;
        w_shift_nxt  = r_shift;
        w_ev_vld     = 1'b0;
        w_ev_type    = c_ev_byte;
        w_ev_nack    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_state_nxt  = ST_ACTIVE;
                    w_bitcnt_nxt = 4'd0;
                    w_ev_vld     = 1'b1;
                    w_ev_type    = c_ev_start;
                end
            end
            ST_ACTIVE: begin
                if (w_start) begin
                    w_bitcnt_nxt = 4'd0;
                    w_ev_vld     = 1'b1;
                    w_ev_type    = c_ev_rstart;
                end else if (w_stop) begin
                    w_state_nxt  = ST_IDLE;
                    w_bitcnt_nxt = 4'd0;
                    w_ev_vld     = 1'b1;
                    w_ev_type    = c_ev_stop;
                end else if (w_scl_rise) begin
                    if (r_bitcnt == 4'd8) begin
                        w_bitcnt_nxt = 4'd0;
                        w_ev_vld     = 1'b1;
                        w_ev_type    = c_ev_byte;
                        w_ev_nack    = w_sda;
                    end else begin
                        w_shift_nxt  = {r_shift[6:0], w_sda};
                        w_bitcnt_nxt = r_bitcnt + 4'd1;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    logic        r_ev_vld;
    logic [10:0] r_ev_word;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_bitcnt   <= 4'd0;
            r_shift    <= 8'h00;
            r_scl_prev <= 1'b1;
            r_sda_prev <= 1'b1;
            r_ev_vld   <= 1'b0;
            r_ev_word  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_bitcnt   <= w_bitcnt_nxt;
            r_shift    <= w_shift_nxt;
            r_scl_prev <= w_scl;
            r_sda_prev <= w_sda;
            r_ev_vld   <= w_ev_vld;
            r_ev_word  <= {w_ev_nack, w_ev_type, (w_ev_type == c_ev_byte) ? r_shift : 8'h00};
        end
    end

    assign bus_busy = (r_state == ST_ACTIVE);

    // ---------------- event FIFO ----------------
    logic [10:0]   r_mem [FIFO_DEPTH];
    logic [c_aw-1:0] r_wr, r_rd;
    logic [c_aw:0]   r_count;
    logic          w_pop, w_push;
    logic [10:0]   w_head;
    logic          r_ovf;

    assign w_pop  = (r_count != '0) && m_axis_tready;
    assign w_push = r_ev_vld && ((r_count != c_depth) || w_pop);
    assign w_head = r_mem[r_rd];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr] <= r_ev_word;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop)  r_rd <= r_rd + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (r_ev_vld && !w_push) begin
                r_ovf <= 1'b1;
            end else if (overflow_clr) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign m_axis_tvalid = (r_count != '0);
    assign m_axis_tdata  = m_axis_tvalid ? w_head[7:0]  : 8'h00;
    assign m_axis_tuser  = m_axis_tvalid ? w_head[10:8] : 3'b000;
    assign overflow      = r_ovf;

    // ---------------- SCL-low timeout ----------------
    logic [c_tw-1:0] r_to_cnt;
    logic            r_timeout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_to_cnt  <= '0;
            r_timeout <= 1'b0;
        end else if (w_start) begin
            r_to_cnt  <= '0;
            r_timeout <= 1'b0;
        end else if (bus_busy && !w_scl) begin
            if (r_to_cnt == c_tmax) begin
                r_timeout <= 1'b1;
            end else begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
        end else begin
            r_to_cnt <= '0;
        end
    end

    assign timeout = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_i2c_bus_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2c_bus_monitor
// Purpose  : Directed plus randomized I2C traffic checked against a
//            transaction-level event model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_bus_monitor;
    localparam int PORTS = 2;
    localparam int FL    = 4;
    localparam int FD    = 16;
    localparam int TO    = 1024;
    localparam int H     = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [PORTS-1:0] scl_o = '1;
    logic [PORTS-1:0] sda_o = '1;
    logic             scl_i = 1'b1;
    logic             sda_i = 1'b1;
    logic             bus_scl, bus_sda;
    logic [7:0]       m_axis_tdata;
    logic [2:0]       m_axis_tuser;
    logic             m_axis_tvalid;
    logic             m_axis_tready = 1'b1;
    logic             bus_busy, overflow, timeout;
    logic             overflow_clr = 1'b0;

    always #5 clk = ~clk;

    i2c_bus_monitor #(.PORTS(PORTS), .FILTER_LEN(FL), .FIFO_DEPTH(FD), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .scl_o(scl_o), .sda_o(sda_o), .scl_i(scl_i), .sda_i(sda_i),
        .bus_scl(bus_scl), .bus_sda(bus_sda), .m_axis_tdata(m_axis_tdata),
        .m_axis_tuser(m_axis_tuser), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .bus_busy(bus_busy), .overflow(overflow),
        .overflow_clr(overflow_clr), .timeout(timeout)
    );

    int          errors = 0;
    int          checks = 0;
    int          cur_port = 0;
    bit          m_active = 1'b0;
    logic [10:0] got[$];
    logic [10:0] exp_q[$];

    always @(negedge clk) begin
        if (rst_n && m_axis_tvalid && m_axis_tready) got.push_back({m_axis_tuser, m_axis_tdata});
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Event model: {nack, type, data}; data is zero for non-BYTE events.
    task automatic m_push(input logic [1:0] ty, input logic [7:0] d, input logic nk);
        exp_q.push_back({nk, ty, (ty == 2'd0) ? d : 8'h00});
    endtask

    task automatic drive(input bit c, input bit d);
        scl_o = '1;
        sda_o = '1;
        scl_o[cur_port] = c;
        sda_o[cur_port] = d;
        tick(H);
    endtask

    task automatic i2c_start();
        drive(1'b0, 1'b1);
        drive(1'b1, 1'b1);
        drive(1'b1, 1'b0);
        drive(1'b0, 1'b0);
        m_push(m_active ? 2'd2 : 2'd1, 8'h00, 1'b0);
        m_active = 1'b1;
    endtask

    task automatic i2c_stop();
        drive(1'b0, 1'b0);
        drive(1'b1, 1'b0);
        drive(1'b1, 1'b1);
        m_push(2'd3, 8'h00, 1'b0);
        m_active = 1'b0;
    endtask

    task automatic i2c_bit(input bit b);
        drive(1'b0, b);
        drive(1'b1, b);
        drive(1'b0, b);
    endtask

    task automatic i2c_byte(input logic [7:0] v, input bit nk);
        for (int i = 7; i >= 0; i--) i2c_bit(v[i]);
        i2c_bit(nk);
        m_push(2'd0, v, nk);
    endtask

    task automatic compare_events(input string tag);
        int n;
        tick(FL + 12);
        check({tag, "_count"}, 32'(got.size()), 32'(exp_q.size()));
        n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
        for (int i = 0; i < n; i++) check({tag, "_event"}, 32'(got[i]), 32'(exp_q[i]));
        got.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [7:0]  v;
        logic [10:0] hold;
        int          nb;

        // Reset values
        tick(3);
        check("rst_tvalid", 32'(m_axis_tvalid), 0);
        check("rst_tdata", 32'(m_axis_tdata), 0);
        check("rst_tuser", 32'(m_axis_tuser), 0);
        check("rst_busy", 32'(bus_busy), 0);
        check("rst_overflow", 32'(overflow), 0);
        check("rst_timeout", 32'(timeout), 0);
        check("rst_bus", 32'({bus_scl, bus_sda}), 32'h3);
        rst_n = 1'b1;
        tick(4);

        // Port 0 writes 0xA0 ACK and 0x5A NACK
        cur_port = 0;
        i2c_start();
        check("t1_busy_start", 32'(bus_busy), 1);
        i2c_byte(8'hA0, 1'b0);
        i2c_byte(8'h5A, 1'b1);
        i2c_stop();
        check("t1_busy_stop", 32'(bus_busy), 0);
        compare_events("t1");

        // Partial byte followed by repeated START
        cur_port = 1;
        i2c_start();
        for (int i = 0; i < 4; i++) i2c_bit(i[0]);
        i2c_start();
        i2c_byte(8'hA1, 1'b0);
        i2c_stop();
        compare_events("t2");

        // Wired-AND resolution
        sda_o = 2'b01;
        tick(H);
        check("t3_port1_low", 32'(bus_sda), 0);
        check("t3_scl_high", 32'(bus_scl), 1);
        m_push(2'd1, 8'h00, 1'b0);
        sda_o = 2'b11;
        sda_i = 1'b0;
        tick(H);
        check("t3_ext_low", 32'(bus_sda), 0);
        sda_i = 1'b1;
        tick(H);
        check("t3_released", 32'(bus_sda), 1);
        m_push(2'd3, 8'h00, 1'b0);
        compare_events("t3");

        // Short SDA glitch while SCL high is filtered out
        sda_o[0] = 1'b0;
        tick(FL - 1);
        sda_o[0] = 1'b1;
        tick(H);
        check("t4_busy", 32'(bus_busy), 0);
        compare_events("t4");

        // Randomized transactions
        for (int t = 0; t < 4; t++) begin
            cur_port = int'($urandom_range(0, PORTS - 1));
            nb = int'($urandom_range(1, 3));
            i2c_start();
            for (int b = 0; b < nb; b++) begin
                v = 8'($urandom);
                i2c_byte(v, 1'($urandom));
                if ($urandom_range(0, 3) == 0) i2c_start();
            end
            i2c_stop();
        end
        compare_events("rand");

        // FIFO overflow with the sink stalled
        m_axis_tready = 1'b0;
        cur_port = 0;
        i2c_start();
        for (int b = 0; b < FD; b++) i2c_byte(8'($urandom), 1'($urandom));
        i2c_stop();
        while (exp_q.size() > FD) void'(exp_q.pop_back());
        tick(FL + 6);
        check("t5_overflow", 32'(overflow), 1);
        check("t5_tvalid", 32'(m_axis_tvalid), 1);
        hold = {m_axis_tuser, m_axis_tdata};
        tick(5);
        check("t5_stable", 32'({m_axis_tuser, m_axis_tdata}), 32'(hold));
        m_axis_tready = 1'b1;
        compare_events("t5");
        check("t5_overflow_sticky", 32'(overflow), 1);
        overflow_clr = 1'b1;
        tick(1);
        overflow_clr = 1'b0;
        check("t5_overflow_clr", 32'(overflow), 0);

        // SCL-low timeout, then reset in the middle of a byte
        cur_port = 1;
        i2c_start();
        tick(TO - 2 * H);
        check("t6_no_timeout", 32'(timeout), 0);
        tick(2 * H + 10);
        check("t6_timeout", 32'(timeout), 1);
        i2c_bit(1'b1);
        i2c_bit(1'b0);
        i2c_bit(1'b1);
        compare_events("t6_pre");
        rst_n = 1'b0;
        tick(1);
        check("t6_rst_tvalid", 32'(m_axis_tvalid), 0);
        check("t6_rst_tdata", 32'(m_axis_tdata), 0);
        check("t6_rst_tuser", 32'(m_axis_tuser), 0);
        check("t6_rst_busy", 32'(bus_busy), 0);
        check("t6_rst_overflow", 32'(overflow), 0);
        check("t6_rst_timeout", 32'(timeout), 0);
        scl_o = '1;
        sda_o = '1;
        m_active = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(H);
        i2c_start();
        i2c_byte(8'($urandom), 1'b0);
        i2c_stop();
        compare_events("t6_post");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog observed=timeout expected=finish");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
